// File: rtl/salu_ctrl_pkg.sv
// Shared types and constants for the SALU issue controller.
package salu_ctrl_pkg;

    localparam int unsigned SALU_DATA_W    = 32;
    localparam int unsigned SALU_MAX_COUNT = 32;

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} salu_ctrl_state_t;
    typedef enum logic {OP_CLZ, OP_CLO} salu_op_t;

    // A leading-count result can never exceed the word width; saturate anything larger.
    function automatic logic [SALU_DATA_W-1:0] clamp_count(input logic [SALU_DATA_W-1:0] r);
        return (r > SALU_DATA_W'(SALU_MAX_COUNT)) ? SALU_DATA_W'(SALU_MAX_COUNT) : r;
    endfunction

endpackage

// File: rtl/salu_rr_arbiter.sv
// Round-robin pick of the first unmasked requester at or above ptr, wrapping modulo NREQ.
module salu_rr_arbiter
#(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned IDX_W = 1
)
(
    input  logic [NREQ-1:0]  req_i,
    input  logic [NREQ-1:0]  mask_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NREQ-1:0]  grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                  input int unsigned     off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return IDX_W'(s);
    endfunction

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = '0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            cand = wrap_idx(ptr_i, off);
            if (!found && req_i[cand] && !mask_i[cand]) begin
                found          = 1'b1;
                grant_o[cand]  = 1'b1;
                idx_o          = cand;
            end
        end
    end

    assign any_o = found;

endmodule

// File: rtl/salu_issue_ctrl.sv
// Arbitrates NREQ issue pipes onto one iterative CLO/CLZ unit, one op in flight,
// sequencing start/busy/flush and returning the tagged count to the owning pipe.
module salu_issue_ctrl
    import salu_ctrl_pkg::*;
#(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned TIMEOUT = 40
)
(
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ-1:0]          req_clo,
    input  logic [NREQ*32-1:0]       req_a,
    input  logic [NREQ*TAG_W-1:0]    req_tag,
    input  logic [NREQ-1:0]          flush,
    output logic [NREQ-1:0]          rsp_valid,
    input  logic [NREQ-1:0]          rsp_ready,
    output logic [SALU_DATA_W-1:0]   rsp_data,
    output logic [TAG_W-1:0]         rsp_tag,
    output logic                     salu_clo,
    output logic                     salu_clz,
    output logic [SALU_DATA_W-1:0]   salu_a,
    input  logic                     salu_busy,
    input  logic [SALU_DATA_W-1:0]   salu_r,
    output logic                     salu_flush,
    output logic                     timeout_err
);

    localparam int unsigned IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned WDOG_W = $clog2(TIMEOUT + 1);

    salu_ctrl_state_t        state_q, state_d;
    salu_op_t                op_q, op_d;
    logic [SALU_DATA_W-1:0]  a_q, a_d;
    logic [TAG_W-1:0]        tag_q, tag_d;
    logic [IDX_W-1:0]        owner_q, owner_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic                    seen_busy_q, seen_busy_d;
    logic [WDOG_W-1:0]       wdog_q, wdog_d;
    logic [SALU_DATA_W-1:0]  rsp_data_q, rsp_data_d;

    logic [NREQ-1:0]         gnt;
    logic [IDX_W-1:0]        gnt_idx;
    logic                    gnt_any;
    logic                    owner_flush;
    logic [IDX_W-1:0]        ptr_inc;

    salu_rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req_i   (req_valid),
        .mask_i  (flush),
        .ptr_i   (ptr_q),
        .grant_o (gnt),
        .idx_o   (gnt_idx),
        .any_o   (gnt_any)
    );

    assign owner_flush = flush[owner_q];
    assign ptr_inc     = (owner_q == IDX_W'(NREQ - 1)) ? '0 : owner_q + IDX_W'(1);

    assign rsp_data = rsp_data_q;
    assign rsp_tag  = tag_q;
    assign salu_a   = a_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            op_q        <= OP_CLZ;
            a_q         <= '0;
            tag_q       <= '0;
            owner_q     <= '0;
            ptr_q       <= '0;
            seen_busy_q <= 1'b0;
            wdog_q      <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            tag_q       <= tag_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            seen_busy_q <= seen_busy_d;
            wdog_q      <= wdog_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        tag_d       = tag_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        seen_busy_d = seen_busy_q;
        wdog_d      = wdog_q;
        rsp_data_d  = rsp_data_q;
        req_ready   = '0;
        rsp_valid   = '0;
        salu_clo    = 1'b0;
        salu_clz    = 1'b0;
        salu_flush  = 1'b0;
        timeout_err = 1'b0;

        case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    req_ready = gnt;
                    for (int unsigned i = 0; i < NREQ; i++) begin
                        if (gnt_idx == IDX_W'(i)) begin
                            op_d  = req_clo[i] ? OP_CLO : OP_CLZ;
                            a_d   = req_a[SALU_DATA_W*i +: SALU_DATA_W];
                            tag_d = req_tag[TAG_W*i +: TAG_W];
                        end
                    end
                    owner_d = gnt_idx;
                    state_d = START;
                end
            end

            START: begin
                if (owner_flush) begin
                    salu_flush = 1'b1;
                    ptr_d      = ptr_inc;
                    state_d    = IDLE;
                end else begin
                    salu_clo    = (op_q == OP_CLO);
                    salu_clz    = (op_q == OP_CLZ);
                    seen_busy_d = 1'b0;
                    wdog_d      = '0;
                    state_d     = WAIT;
                end
            end

            // Completion needs a busy high-then-low edge; a low busy before the unit reacts is ignored.
            WAIT: begin
                if (owner_flush) begin
                    salu_flush = 1'b1;
                    ptr_d      = ptr_inc;
                    state_d    = IDLE;
                end else if (wdog_q == WDOG_W'(TIMEOUT)) begin
                    salu_flush  = 1'b1;
                    timeout_err = 1'b1;
                    ptr_d       = ptr_inc;
                    state_d     = IDLE;
                end else if (seen_busy_q && !salu_busy) begin
                    rsp_data_d = clamp_count(salu_r);
                    state_d    = RESP;
                end else begin
                    if (salu_busy) begin
                        seen_busy_d = 1'b1;
                    end
                    wdog_d = wdog_q + WDOG_W'(1);
                end
            end

            // A flush from the owner drops the response even if it is consumed this cycle.
            RESP: begin
                if (owner_flush) begin
                    ptr_d   = ptr_inc;
                    state_d = IDLE;
                end else begin
                    rsp_valid[owner_q] = 1'b1;
                    if (rsp_ready[owner_q]) begin
                        ptr_d   = ptr_inc;
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // While reset is held, keep the SALU aborted and every handshake quiet.
        if (!resetn) begin
            req_ready   = '0;
            rsp_valid   = '0;
            salu_clo    = 1'b0;
            salu_clz    = 1'b0;
            timeout_err = 1'b0;
            salu_flush  = 1'b1;
        end
    end

endmodule
